time_setter: RTL and testbench

Button-driven time-editing controller that writes the hh:mm:ss counter chain through its parallel-load port. It pauses the counters, captures the running time into a shadow register, and lets the user adjust hours, minutes and seconds with up/down pulses. It then commits all six BCD digits with a one-cycle `load`, or abandons the edit on timeout. It sits between the debounced button front end and the clock counter; its `blink` and `field` outputs go to the display driver.

---
 rtl/time_setter.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_time_setter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_setter.sv
// -----------------------------------------------------------------------------
// time_setter
//
// Button-driven time-editing controller for an hh:mm:ss BCD counter chain.
// On a mode press it pauses the counters and copies the live time into a
// shadow register. The user then steps hours, minutes and (optionally)
// seconds up or down with wrap-around. A final mode press commits the shadow
// through a one-cycle parallel-load strobe. If no button is pressed for
// TIMEOUT_CYCLES cycles, the edit is abandoned and the counters resume from
// the paused value.
//
// Parameters
//   TIMEOUT_CYCLES : idle cycles in an edit state before the edit is dropped
//   BLINK_DIV      : cycles per blink half-period
//
// Ports
//   clk                        : system clock, rising edge
//   clr                        : synchronous active-high reset
//   btn_mode/btn_up/btn_down   : one-cycle debounced button pulses
//   cur_{s0,s1,m0,m1,h0,h1}    : live BCD time from the counter chain
//   run_en                     : counter-chain enable, high only in RUN
//   load                       : one-cycle parallel-load strobe
//   sd0/sd1/md0/md1/hd0/hd1    : shadow BCD digits (load data, edit display)
//   field                      : 0 none, 1 hour, 2 minute, 3 second
//   blink                      : flash square wave, 0 outside edit states
//
// Build option
//   TIME_SETTER_SEC_EDIT_EN : when defined, seconds get their own edit state.
//                             When undefined, the minute edit commits directly
//                             and the seconds are loaded as 00.
// -----------------------------------------------------------------------------
module time_setter #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int BLINK_DIV      = 12_500_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [3:0] cur_s0,
  input  logic [2:0] cur_s1,
  input  logic [3:0] cur_m0,
  input  logic [2:0] cur_m1,
  input  logic [3:0] cur_h0,
  input  logic [1:0] cur_h1,
  output logic       run_en,
  output logic       load,
  output logic [3:0] sd0,
  output logic [2:0] sd1,
  output logic [3:0] md0,
  output logic [2:0] md1,
  output logic [3:0] hd0,
  output logic [1:0] hd1,
  output logic [1:0] field,
  output logic       blink
);

  localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);

  // The counter value seen on the last idle cycle before the timeout fires.
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_EDIT_H = 3'd1,
    ST_EDIT_M = 3'd2,
`ifdef TIME_SETTER_SEC_EDIT_EN
    ST_EDIT_S = 3'd3,
`endif
    ST_COMMIT = 3'd4
  } state_e;

  // Two-digit BCD field; tens is wide enough for any of the three fields.
  typedef struct packed {
    logic [2:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam bcd2_t HOUR_MAX    = '{tens: 3'd2, ones: 4'd3};
  localparam bcd2_t MIN_SEC_MAX = '{tens: 3'd5, ones: 4'd9};

  // One step up or down of a two-digit BCD field that wraps between 00 and
  // max_v. Inputs are assumed legal, so the ones digit only carries at 9 and
  // only borrows at 0.
  function automatic bcd2_t bcd_step(input bcd2_t v, input logic up,
                                     input bcd2_t max_v);
    bcd2_t r;
    r = v;
    if (up) begin
      if (v == max_v) begin
        r = '0;
      end else if (v.ones == 4'd9) begin
        r.tens = v.tens + 3'd1;
        r.ones = 4'd0;
      end else begin
        r.ones = v.ones + 4'd1;
      end
    end else begin
      if (v == '0) begin
        r = max_v;
      end else if (v.ones == 4'd0) begin
        r.tens = v.tens - 3'd1;
        r.ones = 4'd9;
      end else begin
        r.ones = v.ones - 4'd1;
      end
    end
    return r;
  endfunction

  function automatic logic is_edit(input state_e s);
    return (s == ST_EDIT_H) || (s == ST_EDIT_M)
`ifdef TIME_SETTER_SEC_EDIT_EN
           || (s == ST_EDIT_S)
`endif
           ;
  endfunction

  state_e             state_q,     state_d;
  logic               run_en_q,    run_en_d;
  logic               load_q,      load_d;
  logic [1:0]         field_q,     field_d;
  logic               blink_q,     blink_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [IDLE_W-1:0]  idle_q,      idle_d;
  logic [3:0]         sd0_q,       sd0_d;
  logic [2:0]         sd1_q,       sd1_d;
  logic [3:0]         md0_q,       md0_d;
  logic [2:0]         md1_q,       md1_d;
  logic [3:0]         hd0_q,       hd0_d;
  logic [1:0]         hd1_q,       hd1_d;

  logic any_btn;
  logic edit_pulse;
  logic timed_out;

  always_comb begin
    // NOTE: every _d signal gets its hold value first, so no branch can leave
    // one unassigned and infer a latch.
    state_d     = state_q;
    sd0_d       = sd0_q;
    sd1_d       = sd1_q;
    md0_d       = md0_q;
    md1_d       = md1_q;
    hd0_d       = hd0_q;
    hd1_d       = hd1_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    idle_d      = idle_q;
    run_en_d    = 1'b0;
    load_d      = 1'b0;
    field_d     = 2'd0;

    any_btn    = btn_mode | btn_up | btn_down;
    // Up and down together cancel each other out.
    edit_pulse = btn_up ^ btn_down;
    timed_out  = !any_btn && (idle_q >= IDLE_LAST);

    // Mode has priority in every edit state. When it is pressed together with
    // up or down, the field is left untouched.
    case (state_q)
      ST_RUN: begin
        if (btn_mode) begin
          state_d = ST_EDIT_H;
          sd0_d   = cur_s0;
          sd1_d   = cur_s1;
          md0_d   = cur_m0;
          md1_d   = cur_m1;
          hd0_d   = cur_h0;
          hd1_d   = cur_h1;
        end
      end

      ST_EDIT_H: begin
        if (btn_mode) begin
          state_d = ST_EDIT_M;
        end else if (edit_pulse) begin
          // The hour tens digit is only two bits wide; the step never needs
          // the third bit because the hour tops out at 23.
          {hd1_d, hd0_d} = 6'(bcd_step({1'b0, hd1_q, hd0_q}, btn_up, HOUR_MAX));
        end else if (timed_out) begin
          state_d = ST_RUN;
        end
      end

      ST_EDIT_M: begin
        if (btn_mode) begin
`ifdef TIME_SETTER_SEC_EDIT_EN
          state_d = ST_EDIT_S;
`else
          // Seconds cannot be edited in this build, so they are committed as 00.
          state_d = ST_COMMIT;
          sd0_d   = 4'd0;
          sd1_d   = 3'd0;
`endif
        end else if (edit_pulse) begin
          {md1_d, md0_d} = bcd_step({md1_q, md0_q}, btn_up, MIN_SEC_MAX);
        end else if (timed_out) begin
          state_d = ST_RUN;
        end
      end

`ifdef TIME_SETTER_SEC_EDIT_EN
      ST_EDIT_S: begin
        if (btn_mode) begin
          state_d = ST_COMMIT;
        end else if (edit_pulse) begin
          {sd1_d, sd0_d} = bcd_step({sd1_q, sd0_q}, btn_up, MIN_SEC_MAX);
        end else if (timed_out) begin
          state_d = ST_RUN;
        end
      end
`endif

      ST_COMMIT: begin
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // The idle counter only runs while staying inside the edit states with no
    // button activity. Any press, and entry into or exit from editing, clears it.
    if (is_edit(state_q) && is_edit(state_d) && !any_btn) begin
      idle_d = idle_q + IDLE_W'(1);
    end else begin
      idle_d = '0;
    end

    // The blink divider restarts on entry from RUN and then free-runs across
    // the field changes, so the flash phase stays continuous while editing.
    if (!is_edit(state_d)) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (state_q == ST_RUN) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end

    // Outputs are decoded from the next state, so they are registered and
    // line up with the state register.
    run_en_d = (state_d == ST_RUN);
    load_d   = (state_d == ST_COMMIT);
    case (state_d)
      ST_EDIT_H: field_d = 2'd1;
      ST_EDIT_M: field_d = 2'd2;
`ifdef TIME_SETTER_SEC_EDIT_EN
      ST_EDIT_S: field_d = 2'd3;
`endif
      default:   field_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop update from the pre-edge
    // values, regardless of statement order.
    if (clr) begin
      state_q     <= ST_RUN;
      run_en_q    <= 1'b1;
      load_q      <= 1'b0;
      field_q     <= 2'd0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      idle_q      <= '0;
      // NOTE: the shadow digits are plain flops, not a RAM, so they take a
      // reset value like the rest of the state.
      sd0_q       <= 4'd0;
      sd1_q       <= 3'd0;
      md0_q       <= 4'd0;
      md1_q       <= 3'd0;
      hd0_q       <= 4'd0;
      hd1_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      run_en_q    <= run_en_d;
      load_q      <= load_d;
      field_q     <= field_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      idle_q      <= idle_d;
      sd0_q       <= sd0_d;
      sd1_q       <= sd1_d;
      md0_q       <= md0_d;
      md1_q       <= md1_d;
      hd0_q       <= hd0_d;
      hd1_q       <= hd1_d;
    end
  end

  assign run_en = run_en_q;
  assign load   = load_q;
  assign field  = field_q;
  assign blink  = blink_q;
  assign sd0    = sd0_q;
  assign sd1    = sd1_q;
  assign md0    = md0_q;
  assign md1    = md1_q;
  assign hd0    = hd0_q;
  assign hd1    = hd1_q;

endmodule

// File: tb/tb_time_setter.sv
// -----------------------------------------------------------------------------
// tb_time_setter
//
// Scoreboard bench for time_setter. The stimulus process drives one cycle at
// a time and advances a behavioural model that keeps the shadow time as plain
// integers (hours, minutes, seconds) and the mode as a small integer. After
// each clock edge it pushes the expected output word into a queue. A separate
// monitor pops one entry at each falling edge and compares it with the DUT.
// The bench uses small TIMEOUT_CYCLES/BLINK_DIV values so that timeout and
// blink behaviour are reachable.
// -----------------------------------------------------------------------------
module tb_time_setter;

  localparam int TO = 100;
  localparam int BD = 4;
`ifdef TIME_SETTER_SEC_EDIT_EN
  localparam bit SEC_EN = 1'b1;
`else
  localparam bit SEC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr, btn_mode, btn_up, btn_down;
  logic [3:0] cur_s0, cur_m0, cur_h0;
  logic [2:0] cur_s1, cur_m1;
  logic [1:0] cur_h1;
  logic       run_en, load, blink;
  logic [3:0] sd0, md0, hd0;
  logic [2:0] sd1, md1;
  logic [1:0] hd1, field;

  time_setter #(.TIMEOUT_CYCLES(TO), .BLINK_DIV(BD)) dut (
    .clk(clk), .clr(clr), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .cur_s0(cur_s0), .cur_s1(cur_s1), .cur_m0(cur_m0), .cur_m1(cur_m1),
    .cur_h0(cur_h0), .cur_h1(cur_h1),
    .run_en(run_en), .load(load),
    .sd0(sd0), .sd1(sd1), .md0(md0), .md1(md1), .hd0(hd0), .hd1(hd1),
    .field(field), .blink(blink)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s @%0t: dut=%h expected=%h", name, $time, act, req);
  endtask

  typedef struct {
    logic [24:0] vec;
    string       tag;
  } exp_t;

  exp_t  exp_q[$];
  string phase = "reset";

  // ---------------- behavioural reference model ----------------
  // m_st: 0 run, 1 hour edit, 2 minute edit, 3 second edit, 4 commit
  int m_st = 0, m_h = 0, m_m = 0, m_s = 0, m_idle = 0, m_age = 0;
  int m_loads = 0, dut_loads = 0;

  function automatic void model_step(input bit md, input bit up, input bit dn, input bit rst);
    bit was_edit;
    was_edit = (m_st >= 1 && m_st <= 3);
    if (rst) begin
      m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_idle = 0; m_age = 0;
      return;
    end
    if (m_st == 0) begin
      if (md) begin
        m_h = int'(cur_h1) * 10 + int'(cur_h0);
        m_m = int'(cur_m1) * 10 + int'(cur_m0);
        m_s = int'(cur_s1) * 10 + int'(cur_s0);
        m_st = 1;
        m_idle = 0;
      end
    end else if (m_st == 4) begin
      m_st = 0;
    end else begin
      if (md) begin
        m_idle = 0;
        if (m_st == 1) m_st = 2;
        else if (m_st == 2) begin
          if (SEC_EN) m_st = 3;
          else begin m_st = 4; m_s = 0; end
        end else m_st = 4;
      end else if (up || dn) begin
        m_idle = 0;
        if (up != dn) begin
          if (m_st == 1) m_h = (m_h + (up ? 1 : 23)) % 24;
          else if (m_st == 2) m_m = (m_m + (up ? 1 : 59)) % 60;
          else m_s = (m_s + (up ? 1 : 59)) % 60;
        end
      end else begin
        m_idle++;
        if (m_idle >= TO) m_st = 0;
      end
    end
    if (m_st >= 1 && m_st <= 3) m_age = was_edit ? m_age + 1 : 0;
    if (m_st == 4) m_loads++;
  endfunction

  function automatic logic [24:0] model_out();
    bit ed;
    ed = (m_st >= 1 && m_st <= 3);
    return {m_st == 0, m_st == 4, ed ? 2'(m_st) : 2'd0,
            ed ? ((m_age / BD) % 2 == 1) : 1'b0,
            2'(m_h / 10), 4'(m_h % 10), 3'(m_m / 10), 4'(m_m % 10),
            3'(m_s / 10), 4'(m_s % 10)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit md, input bit up, input bit dn, input bit rst);
    exp_t e;
    btn_mode = md; btn_up = up; btn_down = dn; clr = rst;
    @(posedge clk);
    model_step(md, up, dn, rst);
    e.vec = model_out();
    e.tag = phase;
    exp_q.push_back(e);
    #1;
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_h1 = 2'(h / 10); cur_h0 = 4'(h % 10);
    cur_m1 = 3'(m / 10); cur_m0 = 4'(m % 10);
    cur_s1 = 3'(s / 10); cur_s0 = 4'(s % 10);
  endtask

  // Press mode until the edit has been committed and the model is back in RUN.
  task automatic commit_edit();
    for (int i = 0; i < 6 && m_st != 0; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
    end
    idle(2);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (load === 1'b1) dut_loads++;
        check(e.tag, 32'({run_en, load, field, blink, hd1, hd0, md1, md0, sd1, sd0}),
              32'(e.vec));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; clr = 1'b0;
    set_cur(0, 0, 0);

    phase = "reset";
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    phase = "commit_plain";
    set_cur(12, 34, 56);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    commit_edit();

    phase = "hour_wrap";
    set_cur(23, 10, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);          // capture, hour edit
    cyc(1'b0, 1'b1, 1'b0, 1'b0);          // 23 -> 00
    cyc(1'b0, 1'b0, 1'b1, 1'b0);          // 00 -> 23
    repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b0); // 23 -> 19
    cyc(1'b0, 1'b1, 1'b0, 1'b0);          // 19 -> 20
    cyc(1'b1, 1'b0, 1'b0, 1'b0);          // minute edit
    phase = "min_sec_borrow";
    cyc(1'b0, 1'b0, 1'b1, 1'b0);          // minute 10 -> 09
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);          // second 00 -> 59 when seconds editable
    commit_edit();

    phase = "min_wrap";
    set_cur(5, 59, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);          // minute 59 -> 00
    commit_edit();

    phase = "conflicts";
    set_cur(8, 15, 30);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);          // up+down: no change
    cyc(1'b1, 1'b1, 1'b0, 1'b0);          // mode+up: to minute, hour unchanged
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    commit_edit();

    phase = "timeout";
    set_cur(1, 2, 3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(49);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(105);

    phase = "clr_mid_edit";
    set_cur(10, 20, 30);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);          // clr wins over buttons
    idle(2);

    phase = "clr_in_commit";
    set_cur(22, 45, 11);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4 && m_st != 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      int r;
      set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 299) == 0) idle(110);
      if (r < 6)       cyc(1'b1, 1'b0, 1'b0, 1'b0);
      else if (r < 26) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      else if (r < 46) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      else if (r < 50) cyc(1'b0, 1'b1, 1'b1, 1'b0);
      else if (r < 53) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      else if (r < 54) cyc(1'b1, 1'b0, 1'b1, 1'b0);
      else if (r < 55) cyc(1'(($urandom >> 1) & 1), 1'($urandom & 1), 1'b0, 1'b1);
      else             cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end

    phase = "drain";
    idle(2);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("load_pulse_count", 32'(dut_loads), 32'(m_loads));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
